// File: rtl/udma_external_per_stream_adapter.sv
// Width adapter between the uDMA 32-bit channels and the 8-bit external peripheral core.
// TX unpacks little-endian words into bytes; RX packs bytes back into zero-extended words.
module udma_external_per_stream_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [1:0]            cfg_tx_datasize_i,
  input  logic [1:0]            cfg_rx_datasize_i,
  input  logic                  cfg_tx_clr_i,
  input  logic                  cfg_rx_clr_i,
  input  logic [DATA_WIDTH-1:0] data_tx_i,
  input  logic                  data_tx_valid_i,
  output logic                  data_tx_ready_o,
  output logic [BYTE_WIDTH-1:0] ext_tx_data_o,
  output logic                  ext_tx_valid_o,
  input  logic                  ext_tx_ready_i,
  input  logic [BYTE_WIDTH-1:0] ext_rx_data_i,
  input  logic                  ext_rx_valid_i,
  output logic                  ext_rx_ready_o,
  output logic [DATA_WIDTH-1:0] data_rx_o,
  output logic [1:0]            data_rx_datasize_o,
  output logic                  data_rx_valid_o,
  input  logic                  data_rx_ready_i,
  output logic                  tx_busy_o,
  output logic                  rx_busy_o
);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic {RX_ACC, RX_OUT} rx_state_t;

  // Index of the last byte of a beat; size code 11 behaves like a full word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  tx_state_t             tx_state;
  logic [DATA_WIDTH-1:0] tx_word;
  logic [1:0]            tx_last;
  logic [1:0]            tx_idx;
  logic [1:0]            tx_idx_inc;
  logic [DATA_WIDTH-1:0] tx_shifted;

  assign tx_idx_inc = tx_idx + 2'd1;
  assign tx_shifted = tx_word >> {tx_idx_inc, 3'b000};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_state        <= TX_IDLE;
      tx_word         <= '0;
      tx_last         <= '0;
      tx_idx          <= '0;
      data_tx_ready_o <= 1'b1;
      ext_tx_valid_o  <= 1'b0;
      ext_tx_data_o   <= '0;
      tx_busy_o       <= 1'b0;
    end else if (cfg_tx_clr_i) begin
      tx_state        <= TX_IDLE;
      tx_word         <= '0;
      tx_last         <= '0;
      tx_idx          <= '0;
      data_tx_ready_o <= 1'b1;
      ext_tx_valid_o  <= 1'b0;
      ext_tx_data_o   <= '0;
      tx_busy_o       <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (data_tx_valid_i && data_tx_ready_o) begin
            tx_state        <= TX_SHIFT;
            tx_word         <= data_tx_i;
            tx_last         <= last_idx(cfg_tx_datasize_i);
            tx_idx          <= '0;
            ext_tx_data_o   <= data_tx_i[BYTE_WIDTH-1:0];
            ext_tx_valid_o  <= 1'b1;
            data_tx_ready_o <= 1'b0;
            tx_busy_o       <= 1'b1;
          end
        end
        TX_SHIFT: begin
          if (ext_tx_ready_i) begin
            if (tx_idx == tx_last) begin
              tx_state        <= TX_IDLE;
              ext_tx_valid_o  <= 1'b0;
              data_tx_ready_o <= 1'b1;
              tx_busy_o       <= 1'b0;
            end else begin
              tx_idx        <= tx_idx_inc;
              ext_tx_data_o <= tx_shifted[BYTE_WIDTH-1:0];
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  rx_state_t             rx_state;
  logic [DATA_WIDTH-1:0] rx_hold;
  logic [2:0]            rx_cnt;
  logic [1:0]            rx_last;
  logic [1:0]            rx_last_eff;
  logic                  rx_byte_last;
  logic [DATA_WIDTH-1:0] rx_byte_ext;

  // The first byte of a word samples the size live; later bytes use the latched one.
  assign rx_last_eff  = (rx_cnt == 3'd0) ? last_idx(cfg_rx_datasize_i) : rx_last;
  assign rx_byte_last = (rx_cnt[1:0] == rx_last_eff);
  assign rx_byte_ext  = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, ext_rx_data_i};
  assign data_rx_o    = rx_hold;
  assign rx_busy_o    = (rx_cnt != 3'd0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_state           <= RX_ACC;
      rx_hold            <= '0;
      rx_cnt             <= '0;
      rx_last            <= '0;
      data_rx_datasize_o <= 2'b10;
      data_rx_valid_o    <= 1'b0;
      ext_rx_ready_o     <= 1'b1;
    end else if (cfg_rx_clr_i) begin
      rx_state        <= RX_ACC;
      rx_hold         <= '0;
      rx_cnt          <= '0;
      data_rx_valid_o <= 1'b0;
      ext_rx_ready_o  <= 1'b1;
    end else begin
      case (rx_state)
        RX_ACC: begin
          if (ext_rx_valid_i && ext_rx_ready_o) begin
            rx_cnt <= rx_cnt + 3'd1;
            if (rx_cnt == 3'd0) begin
              rx_hold            <= rx_byte_ext;
              rx_last            <= last_idx(cfg_rx_datasize_i);
              data_rx_datasize_o <= cfg_rx_datasize_i;
            end else begin
              rx_hold <= rx_hold | (rx_byte_ext << {rx_cnt[1:0], 3'b000});
            end
            if (rx_byte_last) begin
              rx_state        <= RX_OUT;
              data_rx_valid_o <= 1'b1;
              ext_rx_ready_o  <= 1'b0;
            end
          end
        end
        RX_OUT: begin
          if (data_rx_ready_i) begin
            rx_state        <= RX_ACC;
            rx_cnt          <= '0;
            data_rx_valid_o <= 1'b0;
            ext_rx_ready_o  <= 1'b1;
          end
        end
        default: rx_state <= RX_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_external_per_stream_adapter.sv
// Directed and randomized checks of the stream adapter against a byte-list reference model.
module tb_udma_external_per_stream_adapter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [1:0]  cfg_tx_datasize_i, cfg_rx_datasize_i;
  logic        cfg_tx_clr_i, cfg_rx_clr_i;
  logic [31:0] data_tx_i;
  logic        data_tx_valid_i, data_tx_ready_o;
  logic [7:0]  ext_tx_data_o;
  logic        ext_tx_valid_o, ext_tx_ready_i;
  logic [7:0]  ext_rx_data_i;
  logic        ext_rx_valid_i, ext_rx_ready_o;
  logic [31:0] data_rx_o;
  logic [1:0]  data_rx_datasize_o;
  logic        data_rx_valid_o, data_rx_ready_i;
  logic        tx_busy_o, rx_busy_o;

  int n_assert = 0;
  int n_fail   = 0;

  udma_external_per_stream_adapter dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cfg_tx_datasize_i(cfg_tx_datasize_i), .cfg_rx_datasize_i(cfg_rx_datasize_i),
    .cfg_tx_clr_i(cfg_tx_clr_i), .cfg_rx_clr_i(cfg_rx_clr_i),
    .data_tx_i(data_tx_i), .data_tx_valid_i(data_tx_valid_i), .data_tx_ready_o(data_tx_ready_o),
    .ext_tx_data_o(ext_tx_data_o), .ext_tx_valid_o(ext_tx_valid_o), .ext_tx_ready_i(ext_tx_ready_i),
    .ext_rx_data_i(ext_rx_data_i), .ext_rx_valid_i(ext_rx_valid_i), .ext_rx_ready_o(ext_rx_ready_o),
    .data_rx_o(data_rx_o), .data_rx_datasize_o(data_rx_datasize_o),
    .data_rx_valid_o(data_rx_valid_o), .data_rx_ready_i(data_rx_ready_i),
    .tx_busy_o(tx_busy_o), .rx_busy_o(rx_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] ds);
    return (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
  endfunction

  // Offer one word; expected stream is the first nbytes(ds) bytes, least significant first.
  // mode: 0 = peripheral always ready, 1 = ready toggles every cycle, 2 = random ready.
  task automatic send_tx(input logic [31:0] w, input logic [1:0] ds, input int mode);
    logic [7:0] exp_q[$];
    int cyc, low;
    for (int b = 0; b < nbytes(ds); b++) exp_q.push_back(w[8*b +: 8]);
    cfg_tx_datasize_i = ds;
    data_tx_i = w;
    data_tx_valid_i = 1'b1;
    cyc = 0;
    while (data_tx_ready_o !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    check("tx_accept_ready", {31'd0, data_tx_ready_o}, 32'd1);
    tick();
    data_tx_valid_i = 1'b0;
    data_tx_i = $urandom;
    cfg_tx_datasize_i = 2'($urandom_range(0, 3));
    cyc = 0;
    low = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      ext_tx_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      check("tx_valid", {31'd0, ext_tx_valid_o}, 32'd1);
      check("tx_byte", {24'd0, ext_tx_data_o}, {24'd0, exp_q[0]});
      check("tx_ready_low", {31'd0, data_tx_ready_o}, 32'd0);
      check("tx_busy", {31'd0, tx_busy_o}, 32'd1);
      low++;
      tick();
      if (ext_tx_ready_i) void'(exp_q.pop_front());
      cyc++;
    end
    ext_tx_ready_i = 1'b0;
    check("tx_all_bytes_sent", exp_q.size(), 32'd0);
    check("tx_end_valid", {31'd0, ext_tx_valid_o}, 32'd0);
    check("tx_end_ready", {31'd0, data_tx_ready_o}, 32'd1);
    if (mode == 0) check("tx_ready_low_cycles", low, nbytes(ds));
    $display("TX word %08h ds=%0d mode=%0d done in %0d cycles", w, ds, mode, low);
  endtask

  task automatic send_rx_byte(input logic [7:0] b);
    int cyc;
    ext_rx_data_i = b;
    ext_rx_valid_i = 1'b1;
    cyc = 0;
    while (ext_rx_ready_o !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    check("rx_byte_ready", {31'd0, ext_rx_ready_o}, 32'd1);
    tick();
    ext_rx_valid_i = 1'b0;
    ext_rx_data_i = 8'($urandom);
  endtask

  // Send the low nbytes(ds) bytes of src and expect them back packed and zero-extended.
  task automatic rx_word(input logic [31:0] src, input logic [1:0] ds, input int hold);
    logic [31:0] exp_w, snap;
    exp_w = 32'd0;
    cfg_rx_datasize_i = ds;
    for (int b = 0; b < nbytes(ds); b++) begin
      exp_w = exp_w + (32'(src[8*b +: 8]) << (8*b));
      check("rx_valid_low_acc", {31'd0, data_rx_valid_o}, 32'd0);
      send_rx_byte(src[8*b +: 8]);
      cfg_rx_datasize_i = 2'($urandom_range(0, 2));
      check("rx_busy_acc", {31'd0, rx_busy_o}, 32'd1);
    end
    check("rx_valid", {31'd0, data_rx_valid_o}, 32'd1);
    check("rx_word", data_rx_o, exp_w);
    check("rx_size", {30'd0, data_rx_datasize_o}, {30'd0, ds});
    check("rx_stall", {31'd0, ext_rx_ready_o}, 32'd0);
    snap = exp_w;
    data_rx_ready_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("rx_hold_valid", {31'd0, data_rx_valid_o}, 32'd1);
      check("rx_hold_word", data_rx_o, snap);
      check("rx_hold_stall", {31'd0, ext_rx_ready_o}, 32'd0);
    end
    data_rx_ready_i = 1'b1;
    tick();
    data_rx_ready_i = 1'b0;
    check("rx_after_accept_valid", {31'd0, data_rx_valid_o}, 32'd0);
    check("rx_after_accept_busy", {31'd0, rx_busy_o}, 32'd0);
    $display("RX word %08h ds=%0d hold=%0d", exp_w, ds, hold);
  endtask

  initial begin
    rstn_i = 1'b1;
    cfg_tx_datasize_i = 2'b10; cfg_rx_datasize_i = 2'b10;
    cfg_tx_clr_i = 1'b0; cfg_rx_clr_i = 1'b0;
    data_tx_i = '0; data_tx_valid_i = 1'b0; ext_tx_ready_i = 1'b0;
    ext_rx_data_i = '0; ext_rx_valid_i = 1'b0; data_rx_ready_i = 1'b0;
    #3 rstn_i = 1'b0;
    #4;
    check("rst_tx_ready", {31'd0, data_tx_ready_o}, 32'd1);
    check("rst_tx_valid", {31'd0, ext_tx_valid_o}, 32'd0);
    check("rst_tx_data", {24'd0, ext_tx_data_o}, 32'd0);
    check("rst_rx_ready", {31'd0, ext_rx_ready_o}, 32'd1);
    check("rst_rx_valid", {31'd0, data_rx_valid_o}, 32'd0);
    check("rst_rx_data", data_rx_o, 32'd0);
    check("rst_rx_size", {30'd0, data_rx_datasize_o}, 32'd2);
    check("rst_busy", {30'd0, tx_busy_o, rx_busy_o}, 32'd0);
    tick(); tick();
    rstn_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_valids", {30'd0, ext_tx_valid_o, data_rx_valid_o}, 32'd0);
    end
    $display("Reset and idle checked");

    send_tx(32'hA1B2C3D4, 2'b10, 0);
    send_tx(32'hA1B2C3D4, 2'b10, 1);
    send_tx(32'h000000EE, 2'b00, 0);
    send_tx(32'h00001234, 2'b01, 0);
    send_tx(32'h89ABCDEF, 2'b11, 0);

    rx_word(32'h0000A55A, 2'b01, 5);
    rx_word(32'h000000C3, 2'b00, 0);

    // RX flush with a byte offered on the clear cycle
    cfg_rx_datasize_i = 2'b10;
    send_rx_byte(8'h11);
    send_rx_byte(8'h22);
    check("rx_busy_partial", {31'd0, rx_busy_o}, 32'd1);
    cfg_rx_clr_i = 1'b1; ext_rx_valid_i = 1'b1; ext_rx_data_i = 8'h33;
    tick();
    cfg_rx_clr_i = 1'b0; ext_rx_valid_i = 1'b0;
    check("rx_clr_busy", {31'd0, rx_busy_o}, 32'd0);
    check("rx_clr_valid", {31'd0, data_rx_valid_o}, 32'd0);
    check("rx_clr_ready", {31'd0, ext_rx_ready_o}, 32'd1);
    rx_word(32'h04030201, 2'b10, 0);
    $display("RX flush checked");

    // TX clear after two of four bytes
    cfg_tx_datasize_i = 2'b10; data_tx_i = 32'h55667788; data_tx_valid_i = 1'b1;
    tick();
    data_tx_valid_i = 1'b0; ext_tx_ready_i = 1'b1;
    check("txclr_b0", {24'd0, ext_tx_data_o}, 32'h88);
    tick();
    check("txclr_b1", {24'd0, ext_tx_data_o}, 32'h77);
    tick();
    check("txclr_b2_pending", {24'd0, ext_tx_data_o}, 32'h66);
    cfg_tx_clr_i = 1'b1;
    tick();
    cfg_tx_clr_i = 1'b0; ext_tx_ready_i = 1'b0;
    check("txclr_valid", {31'd0, ext_tx_valid_o}, 32'd0);
    check("txclr_ready", {31'd0, data_tx_ready_o}, 32'd1);
    check("txclr_busy", {31'd0, tx_busy_o}, 32'd0);
    // A word offered on a clear cycle must be ignored
    cfg_tx_clr_i = 1'b1; data_tx_valid_i = 1'b1; data_tx_i = 32'hDEADBEEF;
    tick();
    cfg_tx_clr_i = 1'b0; data_tx_valid_i = 1'b0;
    check("txclr_same_cycle", {31'd0, ext_tx_valid_o}, 32'd0);
    send_tx(32'hCAFEF00D, 2'b10, 0);
    $display("TX clear checked");

    // Asynchronous reset in the middle of both directions
    cfg_rx_datasize_i = 2'b10;
    send_rx_byte(8'h9C);
    data_tx_i = 32'h01020304; data_tx_valid_i = 1'b1;
    tick();
    data_tx_valid_i = 1'b0;
    check("mid_tx_started", {31'd0, ext_tx_valid_o}, 32'd1);
    #2 rstn_i = 1'b0;
    #1;
    check("mid_rst_tx_valid", {31'd0, ext_tx_valid_o}, 32'd0);
    check("mid_rst_tx_ready", {31'd0, data_tx_ready_o}, 32'd1);
    check("mid_rst_busy", {30'd0, tx_busy_o, rx_busy_o}, 32'd0);
    check("mid_rst_rx_data", data_rx_o, 32'd0);
    #2 rstn_i = 1'b1;
    tick();
    $display("Mid-operation reset checked");

    for (int r = 0; r < 20; r++)
      send_tx($urandom, 2'($urandom_range(0, 3)), 2);
    for (int r = 0; r < 20; r++)
      rx_word($urandom, 2'($urandom_range(0, 2)), $urandom_range(0, 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/udma_external_per_stream_adapter.md
Name: udma_external_per_stream_adapter

Overview:
- Datapath stage between the uDMA channel interfaces and the external peripheral core, driven by the datasize fields of the external-peripheral configuration registers.
- TX: unpacks 32-bit uDMA words into a byte stream for the peripheral.
- RX: packs peripheral bytes into words for the uDMA RX channel.
- Both directions are little-endian, use valid/ready handshakes and can be flushed by the channel clear strobes.

Parameters:
- DATA_WIDTH, 32, uDMA data bus width. Fixed at 32; other values unsupported.
- BYTE_WIDTH, 8, peripheral-side data width. Fixed at 8.

Ports:
- clk_i  input  1  clock
- rstn_i  input  1  reset, asynchronous, active-low
- cfg_tx_datasize_i  input  2  TX beat size: 00=1B, 01=2B, 10=4B, 11 treated as 4B
- cfg_rx_datasize_i  input  2  RX beat size, same encoding
- cfg_tx_clr_i  input  1  single-cycle TX flush strobe
- cfg_rx_clr_i  input  1  single-cycle RX flush strobe
- data_tx_i  input  32  word from uDMA TX channel
- data_tx_valid_i  input  1  TX word valid
- data_tx_ready_o  output  1  adapter accepts TX word
- ext_tx_data_o  output  8  byte to peripheral
- ext_tx_valid_o  output  1  byte valid
- ext_tx_ready_i  input  1  peripheral accepts byte
- ext_rx_data_i  input  8  byte from peripheral
- ext_rx_valid_i  input  1  byte valid
- ext_rx_ready_o  output  1  adapter accepts byte
- data_rx_o  output  32  packed word to uDMA RX channel, zero-extended
- data_rx_datasize_o  output  2  datasize of the presented word
- data_rx_valid_o  output  1  RX word valid
- data_rx_ready_i  input  1  uDMA accepts RX word
- tx_busy_o  output  1  TX word in progress
- rx_busy_o  output  1  partial or pending RX word held

Behaviour:
- Reset values: data_tx_ready_o=1, ext_tx_valid_o=0, ext_tx_data_o=0, ext_rx_ready_o=1, data_rx_valid_o=0, data_rx_o=0, data_rx_datasize_o=2'b10, busy outputs 0. All counters and holding registers are cleared.
- Handshake rule: a transfer occurs on a cycle where valid & ready. Valid, once raised, holds with stable data until the transfer.

TX FSM (IDLE, SHIFT):
- IDLE:
  - data_tx_ready_o=1, ext_tx_valid_o=0.
  - On a data_tx handshake: latch the word, latch N=bytes(cfg_tx_datasize_i), set byte index k=0, go to SHIFT.
- SHIFT:
  - data_tx_ready_o=0, ext_tx_valid_o=1, ext_tx_data_o=word[8k+7:8k] (registered output), tx_busy_o=1.
  - On an ext_tx handshake: if k==N-1, go to IDLE; otherwise k++.
- Latency: first byte is valid the cycle after word acceptance.
- Throughput with ext_tx_ready_i held at 1: one word per N+1 cycles.
- Datasize changes mid-word do not affect the word in flight.

RX FSM (ACC, OUT):
- ACC:
  - ext_rx_ready_o=1.
  - On the byte with index j==0, latch N=bytes(cfg_rx_datasize_i) and clear the holding register. That byte is also stored.
  - Each accepted byte is stored at bits [8j+7:8j], then j++.
  - rx_busy_o=1 while j>0.
  - When the N-th byte is accepted, go to OUT.
- OUT:
  - data_rx_valid_o=1, data_rx_o=holding register (upper bytes 0), data_rx_datasize_o=latched size, ext_rx_ready_o=0 (peripheral stalled).
  - On a data_rx handshake: j=0, go to ACC.
  - One idle cycle follows before the next byte can be accepted.
- Latency: data_rx_valid_o rises the cycle after the last byte is accepted.

Clear:
- cfg_tx_clr_i: next state is IDLE, the latched word is discarded, and ext_tx_valid_o drops the following cycle. Clear has priority over any same-cycle handshake; a word offered on the same cycle is not accepted.
- cfg_rx_clr_i: next state is ACC with j=0, discarding any partial or pending word. data_rx_valid_o drops the following cycle; a same-cycle byte is not accepted.
- Reset asserted mid-operation returns every register to its reset value immediately.

Test Plan:
- Reset then idle: outputs at reset values; data_rx_datasize_o=2'b10; no valid asserted for 10 cycles.
- TX word, datasize=10: data_tx_i=0xA1B2C3D4, ext_tx_ready_i=1 -> bytes D4,C3,B2,A1 on consecutive cycles; data_tx_ready_o low for 4 cycles. With ext_tx_ready_i toggling every cycle, bytes are unchanged and held while stalled.
- TX datasize=00 then 01: word 0x000000EE -> single byte EE. Word 0x00001234 -> bytes 34,12. Each word is accepted only in IDLE.
- RX datasize=01: bytes 0x5A,0xA5 -> data_rx_o=0x0000A55A, data_rx_datasize_o=01. With data_rx_ready_i held low for 5 cycles, ext_rx_ready_o=0 throughout and the word is held stable.
- RX flush: datasize=10, send 0x11,0x22, pulse cfg_rx_clr_i, then send 0x01..0x04 -> single word 0x04030201, and rx_busy_o=0 after the clear.
- TX clear mid-word: after 2 of 4 bytes, pulse cfg_tx_clr_i -> ext_tx_valid_o=0 next cycle and data_tx_ready_o=1. The next word 0xCAFEF00D emits 0D,F0,FE,CA.
